// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared pattern-mode type and colour-bar table.
//  Revision    : 1.0 - initial release
// ============================================================================

package display_pkg;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        GRADIENT = 2'd1,
        BARS     = 2'd2,
        CHECKER  = 2'd3
    } pattern_mode_t;

    localparam int NUM_BARS        = 8;
    localparam int BAR_INDEX_WIDTH = 4;

    // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_COLORS [NUM_BARS] = '{
        24'hFFFFFF,
        24'hFFFF00,
        24'h00FFFF,
        24'h00FF00,
        24'hFF00FF,
        24'hFF0000,
        24'h0000FF,
        24'h000000
    };

    // Index 8 marks the remainder pixels to the right of the last bar.
    function automatic logic [23:0] bar_color(input logic [BAR_INDEX_WIDTH-1:0] index);
        return index[3] ? 24'h000000 : BAR_COLORS[index[2:0]];
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : display_pattern
//  Description : Combinational test-pattern colour for one pixel position.
//  Revision    : 1.0 - initial release
// ============================================================================

module display_pattern
    import display_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int CHECK_SHIFT = 5
) (
    input  pattern_mode_t                          mode,
    input  logic signed [COORD_WIDTH-1:0]          x,
    input  logic signed [COORD_WIDTH-1:0]          y,
    input  logic        [BAR_INDEX_WIDTH-1:0]      bar_index,
    input  logic        [23:0]                     color,
    output logic        [23:0]                     rgb
);

    // Only a few coordinate bits select the pattern; the rest are intentionally ignored.
    logic unused_coord_bits;
    assign unused_coord_bits = ^{x, y};

    always_comb begin
        rgb = '0;
        case (mode)
            SOLID:    rgb = color;
            GRADIENT: rgb = {x[7:0], y[7:0], 8'd64};
            BARS:     rgb = bar_color(bar_index);
            CHECKER:  rgb = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? color : 24'h000000;
            default:  rgb = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/display_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing_gen
//  Description : Raster counters, sync pulses and registered test-pattern video.
//  Revision    : 1.0 - initial release
// ============================================================================

module display_timing_gen
    import display_pkg::*;
#(
    parameter int COORD_WIDTH  = 16,
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 720,
    parameter int H_TOTAL      = 900,
    parameter int V_TOTAL      = 820,
    parameter int H_BACK_PORCH = 10,
    parameter int V_BACK_PORCH = 10,
    parameter int HSYNC_DELAY  = 3,
    parameter int CHECK_SHIFT  = 5
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic [1:0]  pattern_mode,
    input  logic [23:0] pattern_color,
    output logic [23:0] video_rgb,
    output logic        video_enable,
    output logic        video_vsync,
    output logic        video_hsync,
    output logic [15:0] frame_count,
    output logic [1:0]  active_mode
);

    localparam logic signed [COORD_WIDTH-1:0] H_START  = COORD_WIDTH'(-H_BACK_PORCH);
    localparam logic signed [COORD_WIDTH-1:0] H_END    = COORD_WIDTH'(H_TOTAL - 1 - H_BACK_PORCH);
    localparam logic signed [COORD_WIDTH-1:0] V_START  = COORD_WIDTH'(-V_BACK_PORCH);
    localparam logic signed [COORD_WIDTH-1:0] V_END    = COORD_WIDTH'(V_TOTAL - 1 - V_BACK_PORCH);
    localparam logic signed [COORD_WIDTH-1:0] H_SYNC_X = COORD_WIDTH'(HSYNC_DELAY - H_BACK_PORCH);
    localparam logic signed [COORD_WIDTH-1:0] H_ACT    = COORD_WIDTH'(H_ACTIVE);
    localparam logic signed [COORD_WIDTH-1:0] V_ACT    = COORD_WIDTH'(V_ACTIVE);

    localparam int                     BAR_W     = H_ACTIVE / NUM_BARS;
    localparam int                     BAR_CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_CNT_W-1:0]   BAR_LAST  = BAR_CNT_W'(BAR_W - 1);

    generate
        if (!(H_TOTAL > H_ACTIVE + H_BACK_PORCH)) begin : g_check_h_total
            $error("display_timing_gen: H_TOTAL must exceed H_ACTIVE + H_BACK_PORCH");
        end
        if (!(V_TOTAL > V_ACTIVE + V_BACK_PORCH)) begin : g_check_v_total
            $error("display_timing_gen: V_TOTAL must exceed V_ACTIVE + V_BACK_PORCH");
        end
        if (!((HSYNC_DELAY >= 1) && (HSYNC_DELAY < H_TOTAL - 1))) begin : g_check_hsync
            $error("display_timing_gen: HSYNC_DELAY must lie in [1, H_TOTAL-2]");
        end
        if (!(H_ACTIVE >= NUM_BARS)) begin : g_check_h_active
            $error("display_timing_gen: H_ACTIVE must be at least 8");
        end
        if (!((COORD_WIDTH >= 8) && (CHECK_SHIFT < COORD_WIDTH))) begin : g_check_coord
            $error("display_timing_gen: COORD_WIDTH too narrow for gradient/checker bits");
        end
    endgenerate

    logic signed [COORD_WIDTH-1:0]     x;
    logic signed [COORD_WIDTH-1:0]     y;
    logic signed [COORD_WIDTH-1:0]     x_next;
    logic signed [COORD_WIDTH-1:0]     y_next;
    logic                              line_end;
    logic                              frame_end;
    logic                              active_now;
    logic [BAR_CNT_W-1:0]              bar_pixel;
    logic [BAR_INDEX_WIDTH-1:0]        bar_index;
    pattern_mode_t                     mode_q;
    logic [23:0]                       pattern_rgb;

    always_comb begin
        line_end   = (x == H_END);
        frame_end  = line_end && (y == V_END);
        x_next     = line_end ? H_START : x + COORD_WIDTH'(1);
        y_next     = (y == V_END) ? V_START : y + COORD_WIDTH'(1);
        active_now = !x[COORD_WIDTH-1] && (x < H_ACT) &&
                     !y[COORD_WIDTH-1] && (y < V_ACT);
    end

    display_pattern #(
        .COORD_WIDTH (COORD_WIDTH),
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_pattern (
        .mode      (mode_q),
        .x         (x),
        .y         (y),
        .bar_index (bar_index),
        .color     (pattern_color),
        .rgb       (pattern_rgb)
    );

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            x <= H_START;
            y <= V_START;
        end else begin
            x <= x_next;
            if (line_end) begin
                y <= y_next;
            end
        end
    end

    // Bar position tracked incrementally so no divider is needed; the counters
    // restart on the clock before x reaches 0 and saturate at index 8 (black).
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            bar_pixel <= '0;
            bar_index <= '0;
        end else if (x_next == '0) begin
            bar_pixel <= '0;
            bar_index <= '0;
        end else if (bar_pixel == BAR_LAST) begin
            bar_pixel <= '0;
            if (!bar_index[3]) begin
                bar_index <= bar_index + BAR_INDEX_WIDTH'(1);
            end
        end else begin
            bar_pixel <= bar_pixel + BAR_CNT_W'(1);
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            video_rgb    <= '0;
            video_enable <= 1'b0;
            video_vsync  <= 1'b0;
            video_hsync  <= 1'b0;
            frame_count  <= '0;
            mode_q       <= SOLID;
        end else begin
            video_enable <= active_now;
            video_rgb    <= active_now ? pattern_rgb : 24'h000000;
            video_vsync  <= frame_end;
            video_hsync  <= (x == H_SYNC_X);
            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
                mode_q      <= pattern_mode_t'(pattern_mode);
            end
        end
    end

    assign active_mode = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_display_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_timing_gen
//  Description : Self-checking bench for display_timing_gen (small raster + wide line).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_display_timing_gen;

    localparam int HA = 16, VA = 4, HT = 24, VT = 8, HBP = 2, VBP = 2, HSD = 3, CS = 1;
    localparam int H_START = -HBP;
    localparam int H_END   = H_START + HT - 1;
    localparam int V_START = -VBP;
    localparam int V_END   = V_START + VT - 1;
    localparam int BAR_W   = HA / 8;
    localparam int FRAME   = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pattern_mode;
    logic [23:0] pattern_color;
    logic [23:0] video_rgb;
    logic        video_enable, video_vsync, video_hsync;
    logic [15:0] frame_count;
    logic [1:0]  active_mode;

    logic        reset_big;
    logic [1:0]  mode_big;
    logic [23:0] color_big;
    logic [23:0] rgb_big;
    logic        enable_big, vsync_big, hsync_big;
    logic [15:0] count_big;
    logic [1:0]  amode_big;

    always #5 clk = ~clk;

    display_timing_gen #(
        .COORD_WIDTH(16), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_BACK_PORCH(HBP), .V_BACK_PORCH(VBP), .HSYNC_DELAY(HSD), .CHECK_SHIFT(CS)
    ) dut (
        .pixel_clock(clk), .reset(reset), .pattern_mode(pattern_mode), .pattern_color(pattern_color),
        .video_rgb(video_rgb), .video_enable(video_enable), .video_vsync(video_vsync),
        .video_hsync(video_hsync), .frame_count(frame_count), .active_mode(active_mode)
    );

    display_timing_gen #(
        .COORD_WIDTH(16), .H_ACTIVE(800), .V_ACTIVE(12), .H_TOTAL(900), .V_TOTAL(16),
        .H_BACK_PORCH(10), .V_BACK_PORCH(2), .HSYNC_DELAY(3), .CHECK_SHIFT(5)
    ) dut_big (
        .pixel_clock(clk), .reset(reset_big), .pattern_mode(mode_big), .pattern_color(color_big),
        .video_rgb(rgb_big), .video_enable(enable_big), .video_vsync(vsync_big),
        .video_hsync(hsync_big), .frame_count(count_big), .active_mode(amode_big)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: t counts clocks since reset release; position follows from t.
    int t = 0, m_fc = 0, m_mode = 0, last_px = -999, last_py = -999;
    logic [23:0] bar_ref [8];

    typedef struct {
        int          mode;
        logic [23:0] color;
        int          px;
        int          py;
        logic [23:0] exp_rgb;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t: wait bound expired", name, $time);
    endtask

    function automatic logic [23:0] ref_pixel(input int mode, input int px, input int py,
                                              input logic [23:0] col);
        int bar;
        case (mode)
            0: return col;
            1: return {8'(px % 256), 8'(py % 256), 8'd64};
            2: begin
                bar = px / BAR_W;
                return (bar < 8) ? bar_ref[bar] : 24'h000000;
            end
            default: return ((((px / 2) + (py / 2)) % 2) == 1) ? col : 24'h000000;
        endcase
    endfunction

    task automatic step();
        logic        rst_in, e_en, e_vs, e_hs;
        int          mode_in, px, py;
        logic [23:0] col_in, e_rgb;
        rst_in  = reset;
        mode_in = int'(pattern_mode);
        col_in  = pattern_color;
        @(posedge clk);
        if (rst_in) begin
            e_rgb = '0; e_en = 0; e_vs = 0; e_hs = 0;
            m_fc = 0; m_mode = 0; t = 0; px = -999; py = -999;
        end else begin
            px    = H_START + (t % HT);
            py    = V_START + ((t / HT) % VT);
            e_en  = (px >= 0) && (px < HA) && (py >= 0) && (py < VA);
            e_rgb = e_en ? ref_pixel(m_mode, px, py, col_in) : 24'h000000;
            e_vs  = (px == H_END) && (py == V_END);
            e_hs  = (px == H_START + HSD);
            if (e_vs) begin
                m_fc   = (m_fc + 1) % 65536;
                m_mode = mode_in;
            end
            t++;
        end
        #1;
        check("cycle", {video_rgb, video_enable, video_vsync, video_hsync, frame_count, active_mode},
              {e_rgb, e_en, e_vs, e_hs, 16'(m_fc), 2'(m_mode)});
        last_px = px;
        last_py = py;
    endtask

    task automatic apply_mode(input int mode, input logic [23:0] col);
        pattern_mode  = 2'(mode);
        pattern_color = col;
        for (int i = 0; i < 2 * FRAME + 4 && m_mode != mode; i++) step();
        check("mode_take", 64'(active_mode), 64'(mode));
    endtask

    task automatic seek(input int px, input int py);
        int i;
        for (i = 0; i < FRAME + 4 && !(last_px == px && last_py == py); i++) step();
        if (!(last_px == px && last_py == py)) timeout("seek");
    endtask

    initial begin
        int first_vs, second_vs, hs_cnt, en_cnt, n;
        bit mode_moved;

        bar_ref = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        vecs[0]  = '{2, 24'h0,      0,  0, 24'hFFFFFF};
        vecs[1]  = '{2, 24'h0,      2,  0, 24'hFFFF00};
        vecs[2]  = '{2, 24'h0,     10,  1, 24'hFF0000};
        vecs[3]  = '{2, 24'h0,     14,  2, 24'h000000};
        vecs[4]  = '{2, 24'h0,     12,  3, 24'h0000FF};
        vecs[5]  = '{2, 24'h0,     -1,  0, 24'h000000};
        vecs[6]  = '{0, 24'h123456, 3,  2, 24'h123456};
        vecs[7]  = '{0, 24'h123456, 15, 3, 24'h123456};
        vecs[8]  = '{0, 24'h123456, 16, 0, 24'h000000};
        vecs[9]  = '{0, 24'h123456, 0,  4, 24'h000000};
        vecs[10] = '{1, 24'h0,      5,  3, 24'h050340};
        vecs[11] = '{1, 24'h0,     15,  0, 24'h0F0040};
        vecs[12] = '{3, 24'hABCDEF, 2,  0, 24'hABCDEF};
        vecs[13] = '{3, 24'hABCDEF, 2,  2, 24'h000000};
        vecs[14] = '{3, 24'hABCDEF, 0,  0, 24'h000000};
        vecs[15] = '{3, 24'hABCDEF, 1,  3, 24'hABCDEF};

        reset = 1'b1; pattern_mode = 2'd0; pattern_color = 24'h0;
        reset_big = 1'b1; mode_big = 2'd1; color_big = 24'h0;
        repeat (3) step();
        check("reset_outputs", {video_rgb, video_enable, video_vsync, video_hsync, frame_count, active_mode}, 64'd0);

        // Two frames from release: sync spacing, enable count, frame counter.
        reset = 1'b0;
        first_vs = -1; second_vs = -1; hs_cnt = 0; en_cnt = 0;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step();
            if (video_vsync) begin
                if (first_vs < 0) first_vs = k;
                else if (second_vs < 0) second_vs = k;
            end
            hs_cnt += int'(video_hsync);
            en_cnt += int'(video_enable);
        end
        check("first_vsync", 64'(first_vs), 64'(FRAME));
        check("second_vsync", 64'(second_vs), 64'(2 * FRAME));
        check("hsync_count", 64'(hs_cnt), 64'(2 * VT));
        check("enable_count", 64'(en_cnt), 64'(2 * HA * VA));
        check("frame_count_2", 64'(frame_count), 64'd2);

        foreach (vecs[i]) begin
            apply_mode(vecs[i].mode, vecs[i].color);
            seek(vecs[i].px, vecs[i].py);
            check($sformatf("vec%0d_rgb", i), 64'(video_rgb), 64'(vecs[i].exp_rgb));
        end

        // Mid-frame mode change is held off until the frame boundary.
        apply_mode(1, 24'h55AA33);
        seek(3, 1);
        pattern_mode = 2'd3;
        mode_moved = 0;
        for (n = 0; n < FRAME + 2; n++) begin
            step();
            if (video_vsync) break;
            if (active_mode != 2'd1) mode_moved = 1;
        end
        if (n >= FRAME + 2) timeout("wait_vsync_switch");
        check("mode_held_midframe", 64'(mode_moved), 64'd0);
        check("mode_switched", 64'(active_mode), 64'd3);
        seek(2, 0);
        check("checker_after_switch", 64'(video_rgb), 64'h55AA33);

        // One-cycle reset in the middle of a frame (state x=5, y=2 at the reset edge).
        apply_mode(0, 24'h123456);
        seek(4, 2);
        reset = 1'b1;
        step();
        check("midreset_outputs", {video_rgb, video_enable, video_vsync, video_hsync, frame_count, active_mode}, 64'd0);
        reset = 1'b0;
        for (n = 1; n <= FRAME + 4; n++) begin
            step();
            if (video_vsync) break;
        end
        check("vsync_after_midreset", 64'(n), 64'(FRAME));
        check("frame_count_after_midreset", 64'(frame_count), 64'd1);

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) pattern_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) pattern_color = 24'($urandom);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;

        // Full-width line: gradient at x=300, y=10.
        reset_big = 1'b0;
        for (n = 1; n <= 20000; n++) begin
            @(posedge clk); #1;
            if (vsync_big) break;
        end
        check("big_first_vsync", 64'(n), 64'(900 * 16));
        check("big_mode", 64'(amode_big), 64'd1);
        repeat ((12 * 900) + 310 + 1) @(posedge clk);
        #1;
        check("big_enable", 64'(enable_big), 64'd1);
        check("big_gradient", 64'(rgb_big), 64'h2C0A40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
